// File: rtl/id_pkg.sv
// id_pkg: shared definitions for the decode stage.
//   - ARM instruction field bit positions
//   - default register count
//   - execute-command encodings produced by control_unit
//   - ctrl_t: the 10-bit ID/EX control bundle
package id_pkg;

    localparam int unsigned NUM_REGS_DEFAULT = 16;

    // Instruction field positions
    localparam int unsigned COND_LSB   = 28;
    localparam int unsigned MODE_LSB   = 26;
    localparam int unsigned I_BIT      = 25;
    localparam int unsigned OPCODE_LSB = 21;
    localparam int unsigned S_BIT      = 20;
    localparam int unsigned RN_LSB     = 16;
    localparam int unsigned RD_LSB     = 12;
    localparam int unsigned RM_LSB     = 0;

    typedef enum logic [1:0] {
        ModeData   = 2'b00,
        ModeMem    = 2'b01,
        ModeBranch = 2'b10
    } mode_e;

    // Data-processing opcodes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Execute commands
    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef struct packed {
        logic [3:0] sigs_control;
        logic       mem_read_en;
        logic       mem_write_en;
        logic       wb_en;
        logic       status_write_en;
        logic       branch_taken;
        logic       immediate;
    } ctrl_t;

endpackage

// File: rtl/condition_check.sv
// condition_check: evaluates the ARM condition field against NZCV.
// Ports:
//   cond   [3:0]  instruction condition field
//   status [3:0]  N, Z, C, V (bit 3 down to bit 0)
//   pass          1 when the instruction should execute
module condition_check (
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = status;

    always_comb begin
        pass = 1'b0;
        case (cond)
            4'h0: pass = z;
            4'h1: pass = ~z;
            4'h2: pass = c;
            4'h3: pass = ~c;
            4'h4: pass = n;
            4'h5: pass = ~n;
            4'h6: pass = v;
            4'h7: pass = ~v;
            4'h8: pass = c & ~z;
            4'h9: pass = ~c | z;
            4'hA: pass = (n == v);
            4'hB: pass = (n != v);
            4'hC: pass = ~z & (n == v);
            4'hD: pass = z | (n != v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: decodes mode/opcode/S into execute command and stage controls.
// Ports:
//   mode [1:0], opcode [3:0], s_bit     instruction fields
//   exe_cmd [3:0]                       ALU command
//   mem_read, mem_write, wb_en          memory and write-back enables
//   status_write, branch                flag update, branch
module control_unit
    import id_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] opcode,
    input  logic       s_bit,
    output logic [3:0] exe_cmd,
    output logic       mem_read,
    output logic       mem_write,
    output logic       wb_en,
    output logic       status_write,
    output logic       branch
);
    always_comb begin
        exe_cmd      = CMD_NOP;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        wb_en        = 1'b0;
        status_write = 1'b0;
        branch       = 1'b0;
        case (mode)
            ModeData: begin
                status_write = s_bit;
                wb_en        = 1'b1;
                case (opcode)
                    OP_MOV: exe_cmd = CMD_MOV;
                    OP_MVN: exe_cmd = CMD_MVN;
                    OP_ADD: exe_cmd = CMD_ADD;
                    OP_ADC: exe_cmd = CMD_ADC;
                    OP_SUB: exe_cmd = CMD_SUB;
                    OP_SBC: exe_cmd = CMD_SBC;
                    OP_AND: exe_cmd = CMD_AND;
                    OP_ORR: exe_cmd = CMD_ORR;
                    OP_EOR: exe_cmd = CMD_EOR;
                    OP_CMP: begin exe_cmd = CMD_SUB; wb_en = 1'b0; end
                    OP_TST: begin exe_cmd = CMD_AND; wb_en = 1'b0; end
                    default: wb_en = 1'b0;
                endcase
            end
            ModeMem: begin
                // S is the load/store select here; address is always base + offset
                exe_cmd   = CMD_ADD;
                mem_read  = s_bit;
                mem_write = ~s_bit;
                wb_en     = s_bit;
            end
            ModeBranch: branch = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/reg_file_bypass.sv
// reg_file_bypass: NUM_REGS x DATA_WIDTH register file, two async read ports,
// one write port on the rising edge. Asynchronous active-high reset clears all.
// With WB_BYPASS_EN defined, a read of the address being written returns the
// write data in the same cycle.
// Ports:
//   clk, reset
//   rd_addr_a/rd_data_a, rd_addr_b/rd_data_b   read ports
//   wr_en, wr_addr, wr_data                    write port
module reg_file_bypass #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
    end
`else
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
`endif
endmodule

// File: rtl/id_stage_regd.sv
// id_stage_regd: decode stage with register read, condition check, hazard
// detection and the ID/EX pipeline register.
// Optional build macro: WB_BYPASS_EN (register-file write-through; removes the
// WB term from the hazard equation).
// Ports:
//   clk, reset (async, active-high)
//   i_Valid, i_Pc, i_Instruction, i_Status       IF/ID inputs and NZCV
//   i_Wb_En/i_Wb_Dest/i_Wb_Value                 register-file write port
//   i_Ex_Wb_En/i_Ex_Dest, i_Mem_Wb_En/i_Mem_Dest in-flight destinations
//   i_Stall, i_Flush                             ID/EX hold / bubble
//   o_Hazard                                     combinational stall request
//   o_*                                          registered ID/EX bundle
module id_stage_regd
    import id_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEFAULT,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Valid,
    input  logic [DATA_WIDTH-1:0] i_Pc,
    input  logic [31:0]           i_Instruction,
    input  logic [3:0]            i_Status,
    input  logic                  i_Wb_En,
    input  logic [REG_ADDR_W-1:0] i_Wb_Dest,
    input  logic [DATA_WIDTH-1:0] i_Wb_Value,
    input  logic                  i_Ex_Wb_En,
    input  logic [REG_ADDR_W-1:0] i_Ex_Dest,
    input  logic                  i_Mem_Wb_En,
    input  logic [REG_ADDR_W-1:0] i_Mem_Dest,
    input  logic                  i_Stall,
    input  logic                  i_Flush,
    output logic                  o_Hazard,
    output logic                  o_Valid,
    output logic [DATA_WIDTH-1:0] o_Pc,
    output logic                  o_Mem_Read_En,
    output logic                  o_Mem_Write_En,
    output logic                  o_Wb_En,
    output logic                  o_Status_Write_En,
    output logic                  o_Branch_Taken,
    output logic                  o_Immediate,
    output logic [3:0]            o_Sigs_Control,
    output logic [DATA_WIDTH-1:0] o_Rn_Value,
    output logic [DATA_WIDTH-1:0] o_Rm_Value,
    output logic [23:0]           o_Signed_Immediate_24,
    output logic [11:0]           o_Shift_Operand,
    output logic [REG_ADDR_W-1:0] o_Destination,
    output logic [REG_ADDR_W-1:0] o_Rn,
    output logic [REG_ADDR_W-1:0] o_Src_2
);
    // Field extraction
    logic [3:0]            cond;
    logic [1:0]            mode;
    logic [3:0]            opcode;
    logic                  s_bit;
    logic [REG_ADDR_W-1:0] rn_idx, rd_idx, rm_idx, src2_idx;

    assign cond   = i_Instruction[COND_LSB +: 4];
    assign mode   = i_Instruction[MODE_LSB +: 2];
    assign opcode = i_Instruction[OPCODE_LSB +: 4];
    assign s_bit  = i_Instruction[S_BIT];
    assign rn_idx = i_Instruction[RN_LSB +: REG_ADDR_W];
    assign rd_idx = i_Instruction[RD_LSB +: REG_ADDR_W];
    assign rm_idx = i_Instruction[RM_LSB +: REG_ADDR_W];

    // Decode
    logic [3:0] dec_cmd;
    logic       dec_mem_read, dec_mem_write, dec_wb_en, dec_status_write, dec_branch;
    logic       cond_pass;

    control_unit u_control_unit (
        .mode         (mode),
        .opcode       (opcode),
        .s_bit        (s_bit),
        .exe_cmd      (dec_cmd),
        .mem_read     (dec_mem_read),
        .mem_write    (dec_mem_write),
        .wb_en        (dec_wb_en),
        .status_write (dec_status_write),
        .branch       (dec_branch)
    );

    condition_check u_condition_check (
        .cond   (cond),
        .status (i_Status),
        .pass   (cond_pass)
    );

    logic  dec_immediate, two_src;
    ctrl_t dec_ctrl;

    assign dec_immediate = i_Instruction[I_BIT];
    assign two_src       = ~dec_immediate | dec_mem_write;
    // A store reads Rd as its data operand
    assign src2_idx      = dec_mem_write ? rd_idx : rm_idx;

    // Null ops (not valid or condition failed) carry all-zero controls
    always_comb begin
        dec_ctrl = '0;
        if (i_Valid && cond_pass) begin
            dec_ctrl.sigs_control    = dec_cmd;
            dec_ctrl.mem_read_en     = dec_mem_read;
            dec_ctrl.mem_write_en    = dec_mem_write;
            dec_ctrl.wb_en           = dec_wb_en;
            dec_ctrl.status_write_en = dec_status_write;
            dec_ctrl.branch_taken    = dec_branch;
            dec_ctrl.immediate       = dec_immediate;
        end
    end

    // Register file
    logic [DATA_WIDTH-1:0] rn_value, src2_value;

    reg_file_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_W     (REG_ADDR_W)
    ) u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (rn_idx),
        .rd_data_a (rn_value),
        .rd_addr_b (src2_idx),
        .rd_data_b (src2_value),
        .wr_en     (i_Wb_En),
        .wr_addr   (i_Wb_Dest),
        .wr_data   (i_Wb_Value)
    );

    // Hazard detection
    function automatic logic reg_match(input logic                  en,
                                       input logic [REG_ADDR_W-1:0] dest,
                                       input logic [REG_ADDR_W-1:0] idx);
        return en && (dest == idx);
    endfunction

    logic hz_rn, hz_src2;

    always_comb begin
        hz_rn   = reg_match(i_Ex_Wb_En, i_Ex_Dest, rn_idx) |
                  reg_match(i_Mem_Wb_En, i_Mem_Dest, rn_idx);
        hz_src2 = reg_match(i_Ex_Wb_En, i_Ex_Dest, src2_idx) |
                  reg_match(i_Mem_Wb_En, i_Mem_Dest, src2_idx);
`ifdef WB_BYPASS_EN
        // Write-through in the register file already covers the WB stage
`else
        hz_rn   = hz_rn | reg_match(i_Wb_En, i_Wb_Dest, rn_idx);
        hz_src2 = hz_src2 | reg_match(i_Wb_En, i_Wb_Dest, src2_idx);
`endif
    end

    // Branch offset bits overlap the Rn field, so branches never source Rn
    assign o_Hazard = i_Valid & cond_pass &
                      ((~dec_branch & hz_rn) | (two_src & hz_src2));

    // ID/EX register
    logic  bubble, load;
    ctrl_t ctrl_q;

    assign bubble = i_Flush | (~i_Stall & o_Hazard);
    assign load   = ~i_Flush & ~i_Stall & ~o_Hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || bubble) begin
            o_Valid               <= 1'b0;
            ctrl_q                <= '0;
            o_Pc                  <= '0;
            o_Rn_Value            <= '0;
            o_Rm_Value            <= '0;
            o_Signed_Immediate_24 <= '0;
            o_Shift_Operand       <= '0;
            o_Destination         <= '0;
            o_Rn                  <= '0;
            o_Src_2               <= '0;
        end else if (load) begin
            o_Valid               <= i_Valid;
            ctrl_q                <= dec_ctrl;
            o_Pc                  <= i_Pc;
            o_Rn_Value            <= rn_value;
            o_Rm_Value            <= src2_value;
            o_Signed_Immediate_24 <= i_Instruction[23:0];
            o_Shift_Operand       <= i_Instruction[11:0];
            o_Destination         <= rd_idx;
            o_Rn                  <= rn_idx;
            o_Src_2               <= src2_idx;
        end
    end

    assign o_Sigs_Control    = ctrl_q.sigs_control;
    assign o_Mem_Read_En     = ctrl_q.mem_read_en;
    assign o_Mem_Write_En    = ctrl_q.mem_write_en;
    assign o_Wb_En           = ctrl_q.wb_en;
    assign o_Status_Write_En = ctrl_q.status_write_en;
    assign o_Branch_Taken    = ctrl_q.branch_taken;
    assign o_Immediate       = ctrl_q.immediate;
endmodule
